// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: shares the board SPI flash between the DSP and CPU masters.
// Define SPI_ARB_TIMEOUT_EN to limit the length of a continuous grant.
module spi_flash_arbiter #(
   parameter int GUARD_CYCLES   = 4,
   parameter int DSP_PRIORITY   = 1,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       dsp_clk,
   input  logic       dsp_mosi,
   input  logic       dsp_cs_INV,
   output logic       dsp_miso,
   input  logic       cpu_clk,
   input  logic       cpu_mosi,
   input  logic       cpu_cs_INV,
   output logic       cpu_miso,
   input  logic       flash_miso,
   output logic       flash_clk,
   output logic       flash_mosi,
   output logic       flash_cs_INV,
   output logic       dsp_grant,
   output logic       cpu_grant,
   output logic [7:0] collision_count
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] GRANT_DSP = 2'd1;
   localparam logic [1:0] GRANT_CPU = 2'd2;
   localparam logic [1:0] GUARD     = 2'd3;

   localparam int GW =
      (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

   logic [1:0]    state;
   logic [1:0]    state_n;
   logic [GW-1:0] guard_cnt;
   logic [GW-1:0] guard_n;

   logic dsp_meta;
   logic s_dsp;
   logic s_dsp_d;
   logic cpu_meta;
   logic s_cpu;
   logic s_cpu_d;

   logic fresh_dsp;
   logic fresh_cpu;

   logic dsp_fall;
   logic dsp_rise;
   logic cpu_fall;
   logic cpu_rise;
   logic dsp_elig;
   logic cpu_elig;
   logic dsp_lost;
   logic cpu_lost;
   logic dsp_tmo;
   logic cpu_tmo;
   logic dsp_pen;
   logic cpu_pen;

   logic [8:0] count_sum;

   // Two-flop CS synchronisers plus a delay flop for edge detection.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         dsp_meta <= 1'b1;
         s_dsp    <= 1'b1;
         s_dsp_d  <= 1'b1;
         cpu_meta <= 1'b1;
         s_cpu    <= 1'b1;
         s_cpu_d  <= 1'b1;
      end else begin
         dsp_meta <= dsp_cs_INV;
         s_dsp    <= dsp_meta;
         s_dsp_d  <= s_dsp;
         cpu_meta <= cpu_cs_INV;
         s_cpu    <= cpu_meta;
         s_cpu_d  <= s_cpu;
      end
   end

   assign dsp_fall = s_dsp_d & ~s_dsp;
   assign dsp_rise = ~s_dsp_d & s_dsp;
   assign cpu_fall = s_cpu_d & ~s_cpu;
   assign cpu_rise = ~s_cpu_d & s_cpu;

   assign dsp_elig = ~s_dsp & fresh_dsp;
   assign cpu_elig = ~s_cpu & fresh_cpu;

   // A request arriving while the other side owns the bus is lost.
   assign dsp_lost = dsp_fall & (state == GRANT_CPU);
   assign cpu_lost = cpu_fall & (state == GRANT_DSP);

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;

   assign tmo_hit = (tmo_cnt == TMO_LAST);
   // A release in the final cycle wins over the timeout penalty.
   assign dsp_tmo = (state == GRANT_DSP) & ~s_dsp & tmo_hit;
   assign cpu_tmo = (state == GRANT_CPU) & ~s_cpu & tmo_hit;

   // Grant length counter, cleared whenever ownership changes.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if ((state_n == state) &&
                   ((state == GRANT_DSP) ||
                    (state == GRANT_CPU))) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
         tmo_cnt <= '0;
      end
   end
`else
   assign dsp_tmo = 1'b0;
   assign cpu_tmo = 1'b0;
`endif

   assign dsp_pen = dsp_lost | dsp_tmo;
   assign cpu_pen = cpu_lost | cpu_tmo;

   // Ownership FSM next state and guard count.
   always_comb begin
      state_n = state;
      guard_n = guard_cnt;
      case (state)
         IDLE: begin
            if (dsp_elig && cpu_elig) begin
               state_n = (DSP_PRIORITY != 0) ?
                         GRANT_DSP : GRANT_CPU;
            end else if (dsp_elig) begin
               state_n = GRANT_DSP;
            end else if (cpu_elig) begin
               state_n = GRANT_CPU;
            end
         end
         GRANT_DSP: begin
            if (s_dsp || dsp_tmo) begin
               state_n = GUARD;
               guard_n = '0;
            end
         end
         GRANT_CPU: begin
            if (s_cpu || cpu_tmo) begin
               state_n = GUARD;
               guard_n = '0;
            end
         end
         GUARD: begin
            if (guard_cnt == GUARD_LAST) begin
               state_n = IDLE;
            end else begin
               guard_n = guard_cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, guard count and grants move together on each edge.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         guard_cnt <= '0;
         dsp_grant <= 1'b0;
         cpu_grant <= 1'b0;
      end else begin
         state     <= state_n;
         guard_cnt <= guard_n;
         dsp_grant <= (state_n == GRANT_DSP);
         cpu_grant <= (state_n == GRANT_CPU);
      end
   end

   // Fresh flags: armed by a CS release, disarmed by a lost request.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         fresh_dsp <= 1'b1;
         fresh_cpu <= 1'b1;
      end else begin
         if (dsp_rise) begin
            fresh_dsp <= 1'b1;
         end else if (dsp_pen) begin
            fresh_dsp <= 1'b0;
         end
         if (cpu_rise) begin
            fresh_cpu <= 1'b1;
         end else if (cpu_pen) begin
            fresh_cpu <= 1'b0;
         end
      end
   end

   assign count_sum = {1'b0, collision_count} +
                      {8'd0, dsp_pen} +
                      {8'd0, cpu_pen};

   // Saturating lost-request counter.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         collision_count <= 8'd0;
      end else if (count_sum[8]) begin
         collision_count <= 8'hFF;
      end else begin
         collision_count <= count_sum[7:0];
      end
   end

   assign flash_cs_INV = ~(dsp_grant & ~dsp_cs_INV) &
                         ~(cpu_grant & ~cpu_cs_INV);
   assign flash_clk  = (dsp_grant & dsp_clk) |
                       (cpu_grant & cpu_clk);
   assign flash_mosi = (dsp_grant & dsp_mosi) |
                       (cpu_grant & cpu_mosi);
   assign dsp_miso   = dsp_grant & flash_miso;
   assign cpu_miso   = cpu_grant & flash_miso;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level ownership model.
module tb_spi_flash_arbiter;

   localparam int G   = 4;
   localparam int TMO = 16;
   localparam bit DSP_PRIO = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic       sysclk     = 1'b0;
   logic       reset      = 1'b0;
   logic       dsp_clk    = 1'b0;
   logic       dsp_mosi   = 1'b0;
   logic       dsp_cs_INV = 1'b1;
   logic       dsp_miso;
   logic       cpu_clk    = 1'b0;
   logic       cpu_mosi   = 1'b0;
   logic       cpu_cs_INV = 1'b1;
   logic       cpu_miso;
   logic       flash_miso = 1'b0;
   logic       flash_clk;
   logic       flash_mosi;
   logic       flash_cs_INV;
   logic       dsp_grant;
   logic       cpu_grant;
   logic [7:0] collision_count;

   int checks = 0;
   int fails  = 0;

   // Reference model: owner 0 = none, 1 = DSP, 2 = CPU.
   int       m_owner;
   int       m_guard;
   int       m_held;
   int       m_count;
   bit       m_fd;
   bit       m_fc;
   logic [2:0] hd;
   logic [2:0] hc;

   spi_flash_arbiter #(
      .GUARD_CYCLES  (G),
      .DSP_PRIORITY  (1),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .sysclk         (sysclk),
      .reset          (reset),
      .dsp_clk        (dsp_clk),
      .dsp_mosi       (dsp_mosi),
      .dsp_cs_INV     (dsp_cs_INV),
      .dsp_miso       (dsp_miso),
      .cpu_clk        (cpu_clk),
      .cpu_mosi       (cpu_mosi),
      .cpu_cs_INV     (cpu_cs_INV),
      .cpu_miso       (cpu_miso),
      .flash_miso     (flash_miso),
      .flash_clk      (flash_clk),
      .flash_mosi     (flash_mosi),
      .flash_cs_INV   (flash_cs_INV),
      .dsp_grant      (dsp_grant),
      .cpu_grant      (cpu_grant),
      .collision_count(collision_count)
   );

   always #5 sysclk = ~sysclk;

   // Model: the FSM sees each pin as it was sampled two edges earlier.
   initial begin : model
      bit vd, vc, pd, pc, rel, ed, ec, tmo, ls_d, ls_c;
      int own, grd, held, cnt;
      m_owner = 0; m_guard = 0; m_held = 0; m_count = 0;
      m_fd = 1'b1; m_fc = 1'b1; hd = 3'b111; hc = 3'b111;
      forever begin
         @(posedge sysclk or posedge reset);
         if (reset) begin
            m_owner = 0; m_guard = 0; m_held = 0; m_count = 0;
            m_fd = 1'b1; m_fc = 1'b1; hd = 3'b111; hc = 3'b111;
         end else begin
            vd = hd[1]; pd = hd[2];
            vc = hc[1]; pc = hc[2];
            ls_d = pd && !vd && (m_owner == 2);
            ls_c = pc && !vc && (m_owner == 1);
            own = m_owner; grd = m_guard; held = m_held; tmo = 0;
            if (m_owner != 0) begin
               rel = (m_owner == 1) ? vd : vc;
               if (rel || (TMO_ON && m_held == TMO)) begin
                  tmo = !rel; own = 0; grd = G; held = 0;
               end else begin
                  held = m_held + 1;
               end
            end else if (m_guard > 0) begin
               grd = m_guard - 1;
            end else begin
               ed = !vd && m_fd;
               ec = !vc && m_fc;
               if (ed && (!ec || DSP_PRIO)) begin
                  own = 1; held = 1;
               end else if (ec) begin
                  own = 2; held = 1;
               end
            end
            if (!pd && vd) m_fd = 1'b1;
            else if (ls_d || (tmo && m_owner == 1)) m_fd = 1'b0;
            if (!pc && vc) m_fc = 1'b1;
            else if (ls_c || (tmo && m_owner == 2)) m_fc = 1'b0;
            cnt = m_count + int'(ls_d) + int'(ls_c) + int'(tmo);
            if (cnt > 255) cnt = 255;
            m_count = cnt; m_owner = own; m_guard = grd; m_held = held;
            hd = {hd[1:0], dsp_cs_INV};
            hc = {hc[1:0], cpu_cs_INV};
         end
      end
   end

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic go_idle();
      dsp_cs_INV = 1'b1;
      cpu_cs_INV = 1'b1;
      repeat (12) tick();
   endtask

   task automatic test_reset();
      flash_miso = 1'b1;
      #1 reset = 1'b1;
      #1;
      checks++;
      if (flash_cs_INV !== 1'b1) begin
         fails++; $display("FAIL reset_cs: got %b want 1", flash_cs_INV);
      end
      checks++;
      if ({dsp_grant, cpu_grant} !== 2'b00) begin
         fails++; $display("FAIL reset_grant: got %b%b want 00", dsp_grant, cpu_grant);
      end
      checks++;
      if (collision_count !== 8'd0) begin
         fails++; $display("FAIL reset_count: got %0d want 0", collision_count);
      end
      checks++;
      if ({dsp_miso, cpu_miso} !== 2'b00) begin
         fails++; $display("FAIL reset_miso: got %b%b want 00", dsp_miso, cpu_miso);
      end
      repeat (3) @(posedge sysclk);
      #1 reset = 1'b0;
      flash_miso = 1'b0;
      repeat (4) tick();
      checks++;
      if ({dsp_grant, cpu_grant} !== 2'b00) begin
         fails++; $display("FAIL idle_grant: got %b%b want 00", dsp_grant, cpu_grant);
      end
   endtask

   task automatic test_single_dsp();
      go_idle();
      dsp_cs_INV = 1'b0;
      tick(); tick();
      checks++;
      if (dsp_grant !== 1'b0) begin
         fails++; $display("FAIL single_early: got %b want 0", dsp_grant);
      end
      tick();
      checks++;
      if (dsp_grant !== 1'b1) begin
         fails++; $display("FAIL single_grant: got %b want 1", dsp_grant);
      end
      for (int i = 0; i < 4; i++) begin
         dsp_clk = 1'($urandom_range(1));
         dsp_mosi = 1'($urandom_range(1));
         flash_miso = 1'($urandom_range(1));
         cpu_clk = ~dsp_clk;
         cpu_mosi = ~dsp_mosi;
         #1;
         checks++;
         if ({flash_clk, flash_mosi, flash_cs_INV} !== {dsp_clk, dsp_mosi, 1'b0}) begin
            fails++; $display("FAIL single_path: got %b%b%b want %b%b0", flash_clk, flash_mosi, flash_cs_INV, dsp_clk, dsp_mosi);
         end
         checks++;
         if ({dsp_miso, cpu_miso} !== {flash_miso, 1'b0}) begin
            fails++; $display("FAIL single_miso: got %b%b want %b0", dsp_miso, cpu_miso, flash_miso);
         end
         tick();
      end
      dsp_cs_INV = 1'b1;
      tick(); tick();
      checks++;
      if (dsp_grant !== 1'b1) begin
         fails++; $display("FAIL release_early: got %b want 1", dsp_grant);
      end
      tick();
      checks++;
      if (dsp_grant !== 1'b0) begin
         fails++; $display("FAIL release_drop: got %b want 0", dsp_grant);
      end
      dsp_cs_INV = 1'b0;
      for (int i = 0; i < G; i++) begin
         tick();
         checks++;
         if ({dsp_grant, flash_cs_INV} !== 2'b01) begin
            fails++; $display("FAIL guard_hold%0d: got grant=%b cs=%b want 0 1", i, dsp_grant, flash_cs_INV);
         end
      end
      tick();
      checks++;
      if ({dsp_grant, flash_cs_INV} !== 2'b10) begin
         fails++; $display("FAIL guard_regrant: got grant=%b cs=%b want 1 0", dsp_grant, flash_cs_INV);
      end
      go_idle();
   endtask

   task automatic test_simultaneous();
      dsp_cs_INV = 1'b0;
      cpu_cs_INV = 1'b0;
      repeat (3) tick();
      checks++;
      if ({dsp_grant, cpu_grant} !== 2'b10) begin
         fails++; $display("FAIL simul_winner: got %b%b want 10", dsp_grant, cpu_grant);
      end
      repeat (3) tick();
      dsp_cs_INV = 1'b1;
      repeat (3) tick();
      checks++;
      if ({dsp_grant, cpu_grant} !== 2'b00) begin
         fails++; $display("FAIL simul_drop: got %b%b want 00", dsp_grant, cpu_grant);
      end
      repeat (G) tick();
      checks++;
      if (cpu_grant !== 1'b0) begin
         fails++; $display("FAIL simul_guard: got %b want 0", cpu_grant);
      end
      tick();
      checks++;
      if (cpu_grant !== 1'b1) begin
         fails++; $display("FAIL simul_loser: got %b want 1", cpu_grant);
      end
      checks++;
      if (collision_count !== 8'd0) begin
         fails++; $display("FAIL simul_count: got %0d want 0", collision_count);
      end
      go_idle();
   endtask

   task automatic test_collision();
      cpu_cs_INV = 1'b0;
      repeat (3) tick();
      dsp_cs_INV = 1'b0;
      tick(); tick();
      checks++;
      if (collision_count !== 8'd0) begin
         fails++; $display("FAIL coll_early: got %0d want 0", collision_count);
      end
      tick();
      checks++;
      if (collision_count !== 8'd1) begin
         fails++; $display("FAIL coll_count: got %0d want 1", collision_count);
      end
      cpu_cs_INV = 1'b1;
      repeat (10) tick();
      checks++;
      if ({dsp_grant, cpu_grant} !== 2'b00) begin
         fails++; $display("FAIL coll_nogrant: got %b%b want 00", dsp_grant, cpu_grant);
      end
      dsp_cs_INV = 1'b1;
      repeat (4) tick();
      dsp_cs_INV = 1'b0;
      tick(); tick();
      checks++;
      if (dsp_grant !== 1'b0) begin
         fails++; $display("FAIL coll_reearly: got %b want 0", dsp_grant);
      end
      tick();
      checks++;
      if (dsp_grant !== 1'b1) begin
         fails++; $display("FAIL coll_regrant: got %b want 1", dsp_grant);
      end
      go_idle();
   endtask

`ifdef SPI_ARB_TIMEOUT_EN
   task automatic test_timeout();
      cpu_cs_INV = 1'b0;
      repeat (3 + TMO - 1) tick();
      checks++;
      if (cpu_grant !== 1'b1) begin
         fails++; $display("FAIL tmo_hold: got %b want 1", cpu_grant);
      end
      tick();
      checks++;
      if (cpu_grant !== 1'b0) begin
         fails++; $display("FAIL tmo_drop: got %b want 0", cpu_grant);
      end
      checks++;
      if (collision_count !== 8'd2) begin
         fails++; $display("FAIL tmo_count: got %0d want 2", collision_count);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (cpu_grant !== 1'b0) begin
            fails++; $display("FAIL tmo_nore%0d: got %b want 0", i, cpu_grant);
         end
      end
      cpu_cs_INV = 1'b1;
      repeat (4) tick();
      cpu_cs_INV = 1'b0;
      repeat (3) tick();
      checks++;
      if (cpu_grant !== 1'b1) begin
         fails++; $display("FAIL tmo_regrant: got %b want 1", cpu_grant);
      end
      go_idle();
   endtask
`else
   task automatic test_long_hold();
      cpu_cs_INV = 1'b0;
      repeat (103) tick();
      checks++;
      if ({cpu_grant, flash_cs_INV} !== 2'b10) begin
         fails++; $display("FAIL hold_grant: got grant=%b cs=%b want 1 0", cpu_grant, flash_cs_INV);
      end
      checks++;
      if (collision_count !== 8'd1) begin
         fails++; $display("FAIL hold_count: got %0d want 1", collision_count);
      end
      go_idle();
   endtask
`endif

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         cpu_cs_INV = 1'b0;
         repeat (3) tick();
         dsp_cs_INV = 1'b0;
         repeat (3) tick();
         cpu_cs_INV = 1'b1;
         dsp_cs_INV = 1'b1;
         repeat (10) tick();
      end
      checks++;
      if (collision_count !== 8'd255) begin
         fails++; $display("FAIL saturate: got %0d want 255", collision_count);
      end
   endtask

   task automatic test_reset_mid_grant();
      go_idle();
      dsp_cs_INV = 1'b0;
      repeat (3) tick();
      checks++;
      if (dsp_grant !== 1'b1) begin
         fails++; $display("FAIL mid_pre: got %b want 1", dsp_grant);
      end
      dsp_clk = 1'b1;
      dsp_mosi = 1'b1;
      flash_miso = 1'b1;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({flash_cs_INV, dsp_grant, cpu_grant} !== 3'b100) begin
         fails++; $display("FAIL mid_reset: got cs=%b g=%b%b want 1 00", flash_cs_INV, dsp_grant, cpu_grant);
      end
      checks++;
      if ({flash_clk, flash_mosi, dsp_miso} !== 3'b000) begin
         fails++; $display("FAIL mid_path: got %b%b%b want 000", flash_clk, flash_mosi, dsp_miso);
      end
      checks++;
      if (collision_count !== 8'd0) begin
         fails++; $display("FAIL mid_count: got %0d want 0", collision_count);
      end
      @(posedge sysclk);
      #1 reset = 1'b0;
      tick(); tick();
      checks++;
      if (dsp_grant !== 1'b0) begin
         fails++; $display("FAIL mid_early: got %b want 0", dsp_grant);
      end
      tick();
      checks++;
      if (dsp_grant !== 1'b1) begin
         fails++; $display("FAIL mid_regrant: got %b want 1", dsp_grant);
      end
      go_idle();
   endtask

   task automatic test_random(input int n);
      logic ecs;
      for (int i = 0; i < n; i++) begin
         tick();
         checks++;
         if ({dsp_grant, cpu_grant} !== {m_owner == 1, m_owner == 2}) begin
            fails++; $display("FAIL rnd_grant@%0d: got %b%b want owner %0d", i, dsp_grant, cpu_grant, m_owner);
         end
         checks++;
         if (dsp_grant && cpu_grant) begin
            fails++; $display("FAIL rnd_excl@%0d: got 11 want at most one", i);
         end
         checks++;
         if (collision_count !== 8'(m_count)) begin
            fails++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, collision_count, m_count);
         end
         if ($urandom_range(9) == 0) dsp_cs_INV = ~dsp_cs_INV;
         if ($urandom_range(9) == 0) cpu_cs_INV = ~cpu_cs_INV;
         dsp_clk = 1'($urandom_range(1));
         dsp_mosi = 1'($urandom_range(1));
         cpu_clk = 1'($urandom_range(1));
         cpu_mosi = 1'($urandom_range(1));
         flash_miso = 1'($urandom_range(1));
         #1;
         ecs = !((m_owner == 1 && !dsp_cs_INV) ||
                 (m_owner == 2 && !cpu_cs_INV));
         checks++;
         if (flash_cs_INV !== ecs) begin
            fails++; $display("FAIL rnd_cs@%0d: got %b want %b", i, flash_cs_INV, ecs);
         end
         checks++;
         if ({flash_clk, flash_mosi} !==
             ((m_owner == 1) ? {dsp_clk, dsp_mosi} :
              (m_owner == 2) ? {cpu_clk, cpu_mosi} : 2'b00)) begin
            fails++; $display("FAIL rnd_path@%0d: got %b%b owner %0d", i, flash_clk, flash_mosi, m_owner);
         end
         checks++;
         if ({dsp_miso, cpu_miso} !==
             {(m_owner == 1) && flash_miso, (m_owner == 2) && flash_miso}) begin
            fails++; $display("FAIL rnd_miso@%0d: got %b%b owner %0d miso %b", i, dsp_miso, cpu_miso, m_owner, flash_miso);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_dsp();
      test_simultaneous();
      test_collision();
`ifdef SPI_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_long_hold();
`endif
      test_saturation();
      test_reset_mid_grant();
      test_random(3000);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
